mm_skew_feeder: RTL and testbench

- Transmit-side driver for the mm systolic PE array. Accepts one k-slice per handshake: column k of A (N row elements) and row k of B (N column elements).
- Skews the slice onto the array's west (row) and north (col) edges. Row lane i and col lane j are each delayed by their lane index.
- Issues the per-tile flush and signals done once the bottom-right PE accumulator holds the final sum.

---
 rtl/mm_skew_feeder.sv | 152 +++++++++++++++
 tb/tb_mm_skew_feeder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_skew_feeder.sv
// mm_skew_feeder: skews A-column / B-row k-slices onto the west and north edges of the mm PE array.
// Optional MM_FEED_ZERO_GATE_EN: lane data is forced to zero whenever its valid is low.
module mm_skew_feeder #(
    parameter int N  = 4,
    parameter int KW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*8-1:0]  row_vec,
    input  logic [N*8-1:0]  col_vec,
    output logic [N*8-1:0]  west_row,
    output logic [N-1:0]    west_valid,
    output logic [N*8-1:0]  north_col,
    output logic            flush,
    output logic            busy,
    output logic            done
);

    localparam int DRAIN_LEN = 2 * N - 1;
    localparam int DW        = $clog2(DRAIN_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [KW-1:0] k_len_q;
    logic [KW-1:0] cnt_q;
    logic [DW-1:0] drain_q;
    logic          accept;
    logic          last_accept;
    logic          drain_end;
    logic [N-1:0]  lane_valid;

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && ((cnt_q + KW'(1)) == k_len_q);
    assign drain_end   = (drain_q == DW'(DRAIN_LEN - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FLUSH;
            S_FLUSH:  state_d = (k_len_q != '0) ? S_STREAM : S_DONE;
            S_STREAM: if (last_accept) state_d = S_DRAIN;
            S_DRAIN:  if (drain_end) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        flush      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        west_valid = lane_valid;
        case (state_q)
            S_IDLE:   busy = 1'b0;
            S_FLUSH: begin
                flush      = 1'b1;
                west_valid = '0;
            end
            S_STREAM: in_ready = (cnt_q < k_len_q);
            S_DONE:   done = 1'b1;
            default:  ;
        endcase
    end

    // Tile depth is captured only from IDLE, so a start mid-tile cannot alter it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_len_q <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && start) begin
                k_len_q <= k_len;
                cnt_q   <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + KW'(1);
            end
            drain_q <= (state_q == S_DRAIN) ? drain_q + DW'(1) : '0;
        end
    end

    // Lane i is an (i+1)-deep chain; row lane i and col lane i share timing, hence one valid chain.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [7:0] row_q [i+1];
        logic [7:0] col_q [i+1];
        logic [i:0] vld_q;
        logic [7:0] row_in;
        logic [7:0] col_in;

`ifdef MM_FEED_ZERO_GATE_EN
        assign row_in = accept ? row_vec[8*i +: 8] : 8'd0;
        assign col_in = accept ? col_vec[8*i +: 8] : 8'd0;
`else
        assign row_in = accept ? row_vec[8*i +: 8] : row_q[0];
        assign col_in = accept ? col_vec[8*i +: 8] : col_q[0];
`endif

        // NOTE: these are flop chains, not RAM, so the data stages are reset alongside the valids.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int d = 0; d <= i; d++) begin
                    row_q[d] <= '0;
                    col_q[d] <= '0;
                end
            end else begin
                vld_q[0] <= accept;
                row_q[0] <= row_in;
                col_q[0] <= col_in;
                for (int d = 1; d <= i; d++) begin
                    vld_q[d] <= vld_q[d-1];
                    row_q[d] <= row_q[d-1];
                    col_q[d] <= col_q[d-1];
                end
            end
        end

        assign lane_valid[i] = vld_q[i];

`ifdef MM_FEED_ZERO_GATE_EN
        assign west_row[8*i +: 8]  = vld_q[i] ? row_q[i] : 8'd0;
        assign north_col[8*i +: 8] = vld_q[i] ? col_q[i] : 8'd0;
`else
        assign west_row[8*i +: 8]  = row_q[i];
        assign north_col[8*i +: 8] = col_q[i];
`endif
    end

endmodule

// File: tb/tb_mm_skew_feeder.sv
// Scoreboard bench for mm_skew_feeder: lane event timing/data, flush/done timing,
// and final sums of a behavioural N x N PE array driven by the feeder outputs.
module tb_mm_skew_feeder;

    localparam int N  = 4;
    localparam int KW = 16;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic           start    = 1'b0;
    logic [KW-1:0]  k_len    = '0;
    logic           in_valid = 1'b0;
    logic [N*8-1:0] row_vec  = '0;
    logic [N*8-1:0] col_vec  = '0;
    logic           in_ready;
    logic [N*8-1:0] west_row;
    logic [N-1:0]   west_valid;
    logic [N*8-1:0] north_col;
    logic           flush;
    logic           busy;
    logic           done;

    mm_skew_feeder #(.N(N), .KW(KW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .k_len      (k_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .row_vec    (row_vec),
        .col_vec    (col_vec),
        .west_row   (west_row),
        .west_valid (west_valid),
        .north_col  (north_col),
        .flush      (flush),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int at;
        int a;
        int b;
    } lane_ev_t;

    lane_ev_t lane_q [N][$];
    int       flush_q[$];
    int       done_q[$];
    int       exp_res [N][N];
    bit       res_chk = 1'b0;

    // Behavioural PE array: operands hop one PE per cycle east (a, valid) and south (b).
    int a_r [N][N];
    int b_r [N][N];
    bit v_r [N][N];
    int acc [N][N];
    int ta  [N][N];
    int tb  [N][N];
    bit tv  [N][N];
    lane_ev_t ev;

    always @(negedge clk) begin
        if (flush) begin
            if (flush_q.size() == 0) check("flush_unexpected", 1, 0);
            else check("flush_cycle", cyc, flush_q.pop_front());
        end
        if (done) begin
            if (done_q.size() == 0) check("done_unexpected", 1, 0);
            else check("done_cycle", cyc, done_q.pop_front());
            if (res_chk) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        check($sformatf("res(%0d,%0d)", i, j), acc[i][j], exp_res[i][j]);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (west_valid[i] === 1'b1) begin
                if (lane_q[i].size() == 0) begin
                    check($sformatf("west_valid_unexpected[%0d]", i), 1, 0);
                end else begin
                    ev = lane_q[i].pop_front();
                    check($sformatf("lane_cycle[%0d]", i), cyc, ev.at);
                    check($sformatf("west_row[%0d]", i), int'($signed(west_row[8*i +: 8])), ev.a);
                    check($sformatf("north_col[%0d]", i), int'($signed(north_col[8*i +: 8])), ev.b);
                end
            end
        end
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    v_r[i][j] = 1'b0;
                    acc[i][j] = 0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ta[i][j] = (j == 0) ? int'($signed(west_row[8*i +: 8])) : a_r[i][j-1];
                    tv[i][j] = (j == 0) ? (west_valid[i] === 1'b1) : v_r[i][j-1];
                    tb[i][j] = (i == 0) ? int'($signed(north_col[8*j +: 8])) : b_r[i-1][j];
                end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    if (flush) acc[i][j] = 0;
                    else if (tv[i][j]) acc[i][j] = acc[i][j] + ta[i][j] * tb[i][j];
                    a_r[i][j] = ta[i][j];
                    b_r[i][j] = tb[i][j];
                    v_r[i][j] = tv[i][j];
                end
        end
    end

    int s = 0;
    logic [N*8-1:0] a_col1 = {8'd4, 8'd3, 8'd2, 8'd1};
    logic [N*8-1:0] b_row1 = {8'd8, 8'd7, 8'd6, 8'd5};
    logic [N*8-1:0] b_rowj = {8'd4, 8'd3, 8'd2, 8'd1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*8-1:0] id_col(input int k);
        logic [N*8-1:0] v;
        v = '0;
        v[8*k +: 8] = 8'd1;
        return v;
    endfunction

    function automatic int lanes_pending();
        int n;
        n = 0;
        for (int i = 0; i < N; i++) n += lane_q[i].size();
        return n;
    endfunction

    task automatic start_tile(input int klen);
        start = 1'b1;
        k_len = KW'(klen);
        s     = cyc;
        flush_q.push_back(s + 1);
        if (klen == 0) done_q.push_back(s + 2);
        tick();
        start = 1'b0;
    endtask

    // Presents one slice until accepted; exp_rel is the accept cycle relative to start.
    task automatic send_slice(input logic [N*8-1:0] rv, input logic [N*8-1:0] cv,
                              input int exp_rel, input bit last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        row_vec  = rv;
        col_vec  = cv;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        check("accept_cycle", (in_ready === 1'b1) ? cyc - s : -1, exp_rel);
        if (in_ready === 1'b1) begin
            for (int i = 0; i < N; i++)
                lane_q[i].push_back('{cyc + 1 + i, int'($signed(rv[8*i +: 8])), int'($signed(cv[8*i +: 8]))});
            if (last) done_q.push_back(cyc + 2 * N);
        end
        tick();
        in_valid = 1'b0;
        if (last) check("in_ready_after_last", int'(in_ready), 0);
    endtask

    task automatic wait_tile_end(input string tag);
        int n;
        n = 0;
        while ((done_q.size() != 0 || busy !== 1'b0 || lanes_pending() != 0) && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, (n < 60) ? 1 : 0, 1);
    endtask

    task automatic set_res_t1();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_res[i][j] = (i + 1) * (j + 5);
        res_chk = 1'b1;
    endtask

    task automatic set_res_ident();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_res[i][j] = j + 1;
        res_chk = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit, expected $finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_west_valid", int'(west_valid), 0);
        check("rst_flush", int'(flush), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        tick();

        // Single slice, k_len=1: flush at +1, accept at +2, done at +10
        set_res_t1();
        start_tile(1);
        send_slice(a_col1, b_row1, 2, 1'b1);
        wait_tile_end("t1");

        // Identity A, B lane j = j+1, back-to-back
        set_res_ident();
        start_tile(4);
        for (int k = 0; k < 4; k++) send_slice(id_col(k), b_rowj, k + 2, k == 3);
        wait_tile_end("t2");

        // Same tile with a two-cycle bubble after the second slice
        start_tile(4);
        send_slice(id_col(0), b_rowj, 2, 1'b0);
        send_slice(id_col(1), b_rowj, 3, 1'b0);
        tick();
        tick();
        send_slice(id_col(2), b_rowj, 6, 1'b0);
        send_slice(id_col(3), b_rowj, 7, 1'b1);
        wait_tile_end("t3");

        // k_len = 0: flush then done, never ready; flush leaves every accumulator at 0
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_res[i][j] = 0;
        start = 1'b1;
        k_len = '0;
        s     = cyc;
        flush_q.push_back(s + 1);
        done_q.push_back(s + 2);
        @(negedge clk);
        check("k0_ready_s0", int'(in_ready), 0);
        check("k0_busy_s0", int'(busy), 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("k0_ready_s1", int'(in_ready), 0);
        check("k0_flush_s1", int'(flush), 1);
        check("k0_west_valid_s1", int'(west_valid), 0);
        tick();
        @(negedge clk);
        check("k0_ready_s2", int'(in_ready), 0);
        check("k0_done_s2", int'(done), 1);
        tick();
        @(negedge clk);
        check("k0_busy_s3", int'(busy), 0);
        tick();

        // Reset during DRAIN abandons the tile
        res_chk = 1'b0;
        start_tile(1);
        send_slice(a_col1, b_row1, 2, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < N; i++) lane_q[i].delete();
        done_q.delete();
        flush_q.delete();
        check("drst_in_ready", int'(in_ready), 0);
        check("drst_west_valid", int'(west_valid), 0);
        check("drst_flush", int'(flush), 0);
        check("drst_busy", int'(busy), 0);
        check("drst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (12) tick();

        // Fresh tile after the abandoned one
        set_res_t1();
        start_tile(1);
        send_slice(a_col1, b_row1, 2, 1'b1);
        wait_tile_end("t5");

        // start pulsed mid-STREAM with a different k_len is ignored
        set_res_ident();
        start_tile(4);
        send_slice(id_col(0), b_rowj, 2, 1'b0);
        start = 1'b1;
        k_len = KW'(7);
        send_slice(id_col(1), b_rowj, 3, 1'b0);
        start = 1'b0;
        k_len = '0;
        send_slice(id_col(2), b_rowj, 4, 1'b0);
        send_slice(id_col(3), b_rowj, 5, 1'b1);
        wait_tile_end("t6");
        repeat (10) tick();
        check("t6_idle", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
